// File: rtl/dp_bidir_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_pkg
// Purpose  : Shared types and helpers for the dual-port bidirectional RAM:
//            FSM state encoding, default geometry and even-parity helper.
// Config   : RAM_PARITY_EN (consumed by the RAM and port files)
// Revision : 1.0 - initial release
// ============================================================================
package dp_ram_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Parity bit that makes the total number of ones even (zero-extend callers)
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage : dp_ram_pkg
`default_nettype wire

// File: rtl/dp_bidir_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dp_bidir_ram_ctrl_if
// Purpose  : Control/status bundle for both RAM ports. The tristate data
//            buses are carried as plain inout ports outside this interface.
// Revision : 1.0 - initial release
// ============================================================================
interface dp_bidir_ram_ctrl_if #(
    parameter int AW = dp_ram_pkg::DEF_AW
);
    logic          cs_0;
    logic          cs_1;
    logic          wr_en_0;
    logic          wr_en_1;
    logic          out_en_0;
    logic          out_en_1;
    logic [AW-1:0] addr_0;
    logic [AW-1:0] addr_1;
    logic          par_inj_0;
    logic          par_inj_1;
    logic          rd_valid_0;
    logic          rd_valid_1;
    logic          par_err_0;
    logic          par_err_1;
    logic          collision;
    logic          busy;

    modport master (
        output cs_0, cs_1, wr_en_0, wr_en_1, out_en_0, out_en_1,
        output addr_0, addr_1, par_inj_0, par_inj_1,
        input  rd_valid_0, rd_valid_1, par_err_0, par_err_1, collision, busy
    );

    modport slave (
        input  cs_0, cs_1, wr_en_0, wr_en_1, out_en_0, out_en_1,
        input  addr_0, addr_1, par_inj_0, par_inj_1,
        output rd_valid_0, rd_valid_1, par_err_0, par_err_1, collision, busy
    );

endinterface : dp_bidir_ram_ctrl_if
`default_nettype wire

// File: rtl/dp_bidir_ram_ctrl_port.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_port
// Purpose  : One RAM port: registered read data, rd_valid / par_err flags
//            and the tristate driver onto the shared data bus.
// Config   : RAM_PARITY_EN - stored word carries a parity bit at [DW]
// Revision : 1.0 - initial release
// ============================================================================
module dp_ram_port
    import dp_ram_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int WW = DEF_DW
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_rd_req,
    input  wire logic          i_out_en,
    input  wire logic          i_wr_cycle,
    input  wire logic [WW-1:0] i_rd_word,
    output logic               o_rd_valid,
    output logic               o_par_err,
    inout  wire      [DW-1:0]  io_data
);

    logic          r_rd_valid;
    logic [DW-1:0] r_rdata;

    // Read-valid flag: one cycle after each accepted request, dropped by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_req;
        end
    end

    // Capture the word as it was before this edge (read-first behaviour)
    always_ff @(posedge clk) begin
        if (i_rd_req) begin
            r_rdata <= i_rd_word[DW-1:0];
        end
    end

`ifdef RAM_PARITY_EN
    logic r_par_err;

    // Parity check accompanies the read data in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= i_rd_req &
                         (i_rd_word[DW] != even_parity(64'(i_rd_word[DW-1:0])));
        end
    end

    assign o_par_err = r_par_err;
`else
    assign o_par_err = 1'b0;
`endif

    assign o_rd_valid = r_rd_valid;

    // The bus is only driven with valid read data, never during this port's write
    assign io_data = (r_rd_valid & i_out_en & ~i_wr_cycle) ? r_rdata : {DW{1'bz}};

endmodule : dp_ram_port
`default_nettype wire

// File: rtl/dp_bidir_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dp_bidir_ram_ctrl
// Purpose  : Parametrised true dual-port RAM with tristate data buses,
//            1-cycle registered reads, write-write collision arbitration
//            (port 0 wins) and an optional post-reset clear sweep.
// Config   : RAM_PARITY_EN - store an even-parity bit per word
// Revision : 1.0 - initial release
// ============================================================================
module dp_bidir_ram_ctrl
    import dp_ram_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter bit CLR_EN = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dp_bidir_ram_ctrl_if.slave bus,
    inout  wire      [DW-1:0]  data_io_0,
    inout  wire      [DW-1:0]  data_io_1
);

    localparam int DEPTH = 2**AW;
`ifdef RAM_PARITY_EN
    localparam int WW = DW + 1;
`else
    localparam int WW = DW;
`endif

    logic [WW-1:0] r_mem [DEPTH];
    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_ptr;
    logic          r_collision;

    logic          w_ready;
    logic          w_wcyc_0;
    logic          w_wcyc_1;
    logic          w_wr_0;
    logic          w_wr_1;
    logic          w_rd_0;
    logic          w_rd_1;
    logic [WW-1:0] w_wword_0;
    logic [WW-1:0] w_wword_1;

    assign w_ready  = (r_state == READY);
    assign w_wcyc_0 = bus.cs_0 & bus.wr_en_0;
    assign w_wcyc_1 = bus.cs_1 & bus.wr_en_1;
    assign w_wr_0   = w_ready & w_wcyc_0;
    assign w_wr_1   = w_ready & w_wcyc_1;
    assign w_rd_0   = w_ready & bus.cs_0 & ~bus.wr_en_0 & bus.out_en_0;
    assign w_rd_1   = w_ready & bus.cs_1 & ~bus.wr_en_1 & bus.out_en_1;

`ifdef RAM_PARITY_EN
    assign w_wword_0 = {even_parity(64'(data_io_0)) ^ bus.par_inj_0, data_io_0};
    assign w_wword_1 = {even_parity(64'(data_io_1)) ^ bus.par_inj_1, data_io_1};
`else
    logic w_unused;
    assign w_unused  = &{1'b0, bus.par_inj_0, bus.par_inj_1};
    assign w_wword_0 = data_io_0;
    assign w_wword_1 = data_io_1;
`endif

    // State register: sweep after reset unless clearing is disabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= CLR_EN ? CLEAR : READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave CLEAR once the last word has been written
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (r_clr_ptr == {AW{1'b1}}) w_state_nxt = READY;
            READY:   w_state_nxt = READY;
            default: w_state_nxt = READY;
        endcase
    end

    // Clear pointer walks every address once during the sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_ptr <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // Memory writes; port 0 is issued last so it wins a same-address clash.
    // An all-zero word also has correct even parity.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_ptr] <= '0;
            end else begin
                if (w_wr_1) r_mem[bus.addr_1] <= w_wword_1;
                if (w_wr_0) r_mem[bus.addr_0] <= w_wword_0;
            end
        end
    end

    // One-cycle pulse when both ports write the same word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_wr_0 & w_wr_1 & (bus.addr_0 == bus.addr_1);
        end
    end

    assign bus.collision = r_collision;
    assign bus.busy      = (r_state == CLEAR);

    dp_ram_port #(.DW(DW), .WW(WW)) u_port_0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_req   (w_rd_0),
        .i_out_en   (bus.out_en_0),
        .i_wr_cycle (w_wcyc_0),
        .i_rd_word  (r_mem[bus.addr_0]),
        .o_rd_valid (bus.rd_valid_0),
        .o_par_err  (bus.par_err_0),
        .io_data    (data_io_0)
    );

    dp_ram_port #(.DW(DW), .WW(WW)) u_port_1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_req   (w_rd_1),
        .i_out_en   (bus.out_en_1),
        .i_wr_cycle (w_wcyc_1),
        .i_rd_word  (r_mem[bus.addr_1]),
        .o_rd_valid (bus.rd_valid_1),
        .o_par_err  (bus.par_err_1),
        .io_data    (data_io_1)
    );

endmodule : dp_bidir_ram_ctrl
`default_nettype wire

// File: tb/tb_dp_bidir_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_bidir_ram_ctrl
// Purpose  : Self-checking bench for dp_bidir_ram_ctrl (DW=8, AW=4, CLR_EN=1)
//            with a word-level reference model and directed literal checks.
// Config   : RAM_PARITY_EN - adds the parity-inject scenario
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_bidir_ram_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    dp_bidir_ram_ctrl_if #(.AW(AW)) bus ();
    wire  [DW-1:0] data_io_0;
    wire  [DW-1:0] data_io_1;

    // Stimulus state (index = port)
    bit            s_cs  [2];
    bit            s_wr  [2];
    bit            s_oe  [2];
    logic [AW-1:0] s_a   [2];
    logic [DW-1:0] s_d   [2];
    bit            s_inj [2];

    // Reference model state
    int            busy_cnt = 0;
    logic [DW-1:0] mmem [DEPTH];
    bit            mbad [DEPTH];
    bit            mv   [2] = '{1'b0, 1'b0};
    logic [DW-1:0] md   [2];
    bit            mpe  [2] = '{1'b0, 1'b0};
    bit            mcoll = 1'b0;
    bit            armed = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    // The bench owns the bus whenever the model says the block must not drive it
    logic tb_oe0, tb_oe1;
    assign tb_oe0 = !(mv[0] && s_oe[0] && !(s_cs[0] && s_wr[0]));
    assign tb_oe1 = !(mv[1] && s_oe[1] && !(s_cs[1] && s_wr[1]));
    assign data_io_0 = tb_oe0 ? s_d[0] : {DW{1'bz}};
    assign data_io_1 = tb_oe1 ? s_d[1] : {DW{1'bz}};

    dp_bidir_ram_ctrl #(.DW(DW), .AW(AW), .CLR_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .data_io_0 (data_io_0),
        .data_io_1 (data_io_1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Word-level model of one clock edge
    task automatic model_step();
        if (!rst_n) begin
            busy_cnt = DEPTH;
            mv[0] = 1'b0; mv[1] = 1'b0;
            mpe[0] = 1'b0; mpe[1] = 1'b0;
            mcoll = 1'b0;
        end else if (busy_cnt > 0) begin
            mmem[DEPTH - busy_cnt] = '0;
            mbad[DEPTH - busy_cnt] = 1'b0;
            busy_cnt--;
            mv[0] = 1'b0; mv[1] = 1'b0;
            mpe[0] = 1'b0; mpe[1] = 1'b0;
            mcoll = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                mv[p]  = s_cs[p] && !s_wr[p] && s_oe[p];
                mpe[p] = 1'b0;
                if (mv[p]) begin
                    md[p] = mmem[s_a[p]];
`ifdef RAM_PARITY_EN
                    mpe[p] = mbad[s_a[p]];
`endif
                end
            end
            mcoll = s_cs[0] && s_wr[0] && s_cs[1] && s_wr[1] && (s_a[0] == s_a[1]);
            for (int p = 1; p >= 0; p--) begin
                if (s_cs[p] && s_wr[p]) begin
                    mmem[s_a[p]] = s_d[p];
                    mbad[s_a[p]] = s_inj[p];
                end
            end
        end
    endtask

    task automatic step(input bit rn,
                        input bit c0, input bit w0, input bit o0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input bit i0,
                        input bit c1, input bit w1, input bit o1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1, input bit i1);
        rst_n = rn;
        s_cs[0] = c0; s_wr[0] = w0; s_oe[0] = o0; s_a[0] = a0; s_inj[0] = i0;
        s_cs[1] = c1; s_wr[1] = w1; s_oe[1] = o1; s_a[1] = a1; s_inj[1] = i1;
        s_d[0] = w0 ? d0 : DW'($urandom);
        s_d[1] = w1 ? d1 : DW'($urandom);
        bus.cs_0 = c0; bus.wr_en_0 = w0; bus.out_en_0 = o0; bus.addr_0 = a0; bus.par_inj_0 = i0;
        bus.cs_1 = c1; bus.wr_en_1 = w1; bus.out_en_1 = o1; bus.addr_1 = a1; bus.par_inj_1 = i1;
        @(posedge clk);
        model_step();
        armed = 1'b1;
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rd0(input logic [AW-1:0] a);
        step(1'b1, 1'b1, 1'b0, 1'b1, a, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_busy_low(input string nm);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 40 && bus.busy; k++) begin
            cnt++;
            idle();
        end
        chk(nm, 32'(cnt), 32'd16);
    endtask

    // Compare every output against the model once per cycle, away from the edge
    always @(negedge clk) begin
        if (armed) begin
            chk("rd_valid_0", 32'(bus.rd_valid_0), 32'(mv[0]));
            chk("rd_valid_1", 32'(bus.rd_valid_1), 32'(mv[1]));
            chk("par_err_0",  32'(bus.par_err_0),  32'(mpe[0]));
            chk("par_err_1",  32'(bus.par_err_1),  32'(mpe[1]));
            chk("collision",  32'(bus.collision),  32'(mcoll));
            chk("busy",       32'(bus.busy),       32'(busy_cnt > 0));
            chk("data_io_0",  32'(data_io_0), 32'(tb_oe0 ? s_d[0] : md[0]));
            chk("data_io_1",  32'(data_io_1), 32'(tb_oe1 ? s_d[1] : md[1]));
        end
    end

    initial begin
        // Reset and clear sweep length
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        wait_busy_low("busy_cycles");

        // Every word reads back zero after the sweep
        for (int a = 0; a < DEPTH; a++) begin
            rd0(AW'(a));
            chk("clr_valid", 32'(bus.rd_valid_0), 32'd1);
            chk("clr_data",  32'(data_io_0), 32'h00);
        end
        idle();

        // Port 0 writes, port 1 reads the same word next cycle
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, '0, 1'b0);
        chk("xport_valid", 32'(bus.rd_valid_1), 32'd1);
        chk("xport_data",  32'(data_io_1), 32'hA5);
        chk("xport_p0_idle", 32'(bus.rd_valid_0), 32'd0);

        // Same-address write/write: port 0 wins, one collision pulse
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 8'h22, 1'b0);
        chk("coll_pulse", 32'(bus.collision), 32'd1);
        idle();
        chk("coll_clear", 32'(bus.collision), 32'd0);
        rd0(4'd7);
        chk("coll_winner", 32'(data_io_0), 32'h11);

        // Write on port 1 while port 0 reads the same word: old data first
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, '0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 8'h3C, 1'b0);
        chk("rf_old", 32'(data_io_0), 32'h00);
        chk("rf_nocoll", 32'(bus.collision), 32'd0);
        rd0(4'd9);
        chk("rf_new", 32'(data_io_0), 32'h3C);

        // Reset in the middle of a read burst
        rd0(4'd3);
        rd0(4'd7);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("rst_valid", 32'(bus.rd_valid_0), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd1);
        wait_busy_low("busy_recover");
        rd0(4'd3);
        chk("rst_cleared", 32'(data_io_0), 32'h00);

`ifdef RAM_PARITY_EN
        // Injected parity error, then a clean rewrite
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        rd0(4'd2);
        chk("par_inj_err", 32'(bus.par_err_0), 32'd1);
        chk("par_inj_data", 32'(data_io_0), 32'hF0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        rd0(4'd2);
        chk("par_clean", 32'(bus.par_err_0), 32'd0);
`endif

        // Randomised traffic with occasional resets
        for (int i = 0; i < 1200; i++) begin
            bit            rn, narrow;
            bit            c [2];
            bit            w [2];
            bit            o [2];
            bit            inj [2];
            logic [AW-1:0] a [2];
            logic [DW-1:0] d [2];
            rn     = ($urandom_range(0, 249) != 0);
            narrow = $urandom_range(0, 1) == 1;
            for (int p = 0; p < 2; p++) begin
                c[p]   = $urandom_range(0, 3) != 0;
                w[p]   = $urandom_range(0, 2) == 0;
                o[p]   = $urandom_range(0, 3) != 0;
                inj[p] = $urandom_range(0, 4) == 0;
                a[p]   = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
                d[p]   = DW'($urandom);
            end
            step(rn, c[0], w[0], o[0], a[0], d[0], inj[0],
                     c[1], w[1], o[1], a[1], d[1], inj[1]);
        end
        idle();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule : tb_dp_bidir_ram_ctrl
`default_nettype wire
